// File: rtl/spi_load_pkg.sv
// Shared types and constants for the SPI program loader path.
// Entry layout, loader command bytes and load base addresses.
package spi_load_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [7:0] CMD_WR_REG = 8'h01;
  localparam logic [7:0] CMD_WR_MEM = 8'h02;

  localparam logic [31:0] BASE_REG = 32'h0000_0000;
  localparam logic [31:0] BASE_MEM = 32'h0010_0000;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } rb_entry_t;

  function automatic rb_entry_t mk_entry(
    input logic              last,
    input logic [DATA_W-1:0] data
  );
    rb_entry_t e;
    e.last = last;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/spi_rb_fifo.sv
// Show-ahead storage for the read buffer: array, pointers, level.
// Head entry is a plain mux of registered state, no read latency.
module spi_rb_fifo
  import spi_load_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LW    = AW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [DATA_W:0] wdata_i,
  output logic [DATA_W:0] rdata_o,
  output logic [LW-1:0]   level_o,
  output logic            full_o,
  output logic            empty_o
);

  logic [DATA_W:0] mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  // Next pointers and occupancy; flush wins over any traffic.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  // Pointer and level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage write; contents are masked by level so need no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/spi_read_buffer.sv
// Show-ahead read buffer between the host stream and SPI loader.
// Adds stream handshake, frame tracking, counters, sticky flags.
module spi_read_buffer
  import spi_load_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        s_axis_tdata,
  input  logic                     s_axis_tvalid,
  input  logic                     s_axis_tlast,
  output logic                     s_axis_tready,
  input  logic                     flush,
  output logic [DATA_W-1:0]        spi_data,
  output logic                     valid_o,
  output logic                     last_o,
  input  logic                     rb_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         words_in,
  output logic [CNT_W-1:0]         words_out,
  output logic                     frame_done,
  output logic                     underflow
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [DATA_W:0] head;
  logic [LW-1:0]   fifo_level;
  logic            fifo_full, fifo_empty;
  logic            push, pop;

  logic             acc_last_q, acc_last_d;
  logic             done_q, done_d;
  logic             uflow_q, uflow_d;
  logic [CNT_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] wout_q, wout_d;

  spi_rb_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({s_axis_tlast, s_axis_tdata}),
    .rdata_o (head),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Ready drops in reset, when full, after tlast, and on flush.
  assign s_axis_tready = rst_n && !fifo_full && !acc_last_q && !flush;

  assign push = s_axis_tvalid && s_axis_tready;
  assign pop  = rb_ready && !fifo_empty && !flush;

  assign valid_o    = !fifo_empty;
  assign spi_data   = valid_o ? head[DATA_W-1:0] : '0;
  assign last_o     = valid_o && head[DATA_W];
  assign level      = fifo_level;
  assign words_in   = win_q;
  assign words_out  = wout_q;
  assign frame_done = done_q;
  assign underflow  = uflow_q;

  // Frame status and counters; a pop of an empty buffer after the
  // frame finished is the loader idling, not an underflow.
  always_comb begin
    acc_last_d = acc_last_q;
    done_d     = done_q;
    uflow_d    = uflow_q;
    win_d      = win_q;
    wout_d     = wout_q;
    if (push) begin
      win_d = win_q + CNT_W'(1);
      if (s_axis_tlast) acc_last_d = 1'b1;
    end
    if (pop) begin
      wout_d = wout_q + CNT_W'(1);
      if (head[DATA_W]) done_d = 1'b1;
    end
    if (rb_ready && fifo_empty && !done_q) uflow_d = 1'b1;
    if (flush) begin
      acc_last_d = 1'b0;
      done_d     = 1'b0;
      uflow_d    = 1'b0;
      win_d      = '0;
      wout_d     = '0;
    end
  end

  // Frame status and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_last_q <= 1'b0;
      done_q     <= 1'b0;
      uflow_q    <= 1'b0;
      win_q      <= '0;
      wout_q     <= '0;
    end else begin
      acc_last_q <= acc_last_d;
      done_q     <= done_d;
      uflow_q    <= uflow_d;
      win_q      <= win_d;
      wout_q     <= wout_d;
    end
  end

endmodule

// File: tb/tb_spi_read_buffer.sv
// Testbench for spi_read_buffer: queue model plus per-cycle compare.
// Directed scenarios followed by a randomized traffic phase.
module tb_spi_read_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int CW    = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic          flush;
  logic [DW-1:0] spi_data;
  logic          valid_o;
  logic          last_o;
  logic          rb_ready;
  logic [4:0]    level;
  logic [CW-1:0] words_in;
  logic [CW-1:0] words_out;
  logic          frame_done;
  logic          underflow;

  int checks = 0;
  int errors = 0;

  spi_read_buffer #(
    .DATA_W (DW),
    .DEPTH  (DEPTH),
    .CNT_W  (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .flush         (flush),
    .spi_data      (spi_data),
    .valid_o       (valid_o),
    .last_o        (last_o),
    .rb_ready      (rb_ready),
    .level         (level),
    .words_in      (words_in),
    .words_out     (words_out),
    .frame_done    (frame_done),
    .underflow     (underflow)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of {last,data} plus frame bookkeeping.
  logic [DW:0]  mq[$];
  int unsigned  m_win, m_wout;
  bit           m_acc, m_done, m_uf;

  function automatic bit m_tready();
    return rst_n && !flush && (mq.size() < DEPTH) && !m_acc;
  endfunction

  function automatic void m_clear();
    mq.delete();
    m_win  = 0;
    m_wout = 0;
    m_acc  = 0;
    m_done = 0;
    m_uf   = 0;
  endfunction

  function automatic void m_edge();
    bit          do_push;
    bit          do_pop;
    logic [DW:0] e;
    if (!rst_n || flush) begin
      m_clear();
      return;
    end
    do_push = s_axis_tvalid && m_tready();
    do_pop  = rb_ready && (mq.size() != 0);
    if (rb_ready && mq.size() == 0 && !m_done) m_uf = 1;
    if (do_pop) begin
      e = mq.pop_front();
      if (e[DW]) m_done = 1;
      m_wout++;
    end
    if (do_push) begin
      mq.push_back({s_axis_tlast, s_axis_tdata});
      m_win++;
      if (s_axis_tlast) m_acc = 1;
    end
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare every output against the model on the falling edge.
  always @(negedge clk) begin
    logic [DW:0] hd;
    hd = (mq.size() != 0) ? mq[0] : '0;
    chk("valid_o", 64'(valid_o), 64'(mq.size() != 0));
    chk("spi_data", 64'(spi_data), 64'(hd[DW-1:0]));
    chk("last_o", 64'(last_o), 64'(hd[DW]));
    chk("level", 64'(level), 64'(mq.size()));
    chk("tready", 64'(s_axis_tready), 64'(m_tready()));
    chk("words_in", 64'(words_in), 64'(m_win));
    chk("words_out", 64'(words_out), 64'(m_wout));
    chk("frame_done", 64'(frame_done), 64'(m_done));
    chk("underflow", 64'(underflow), 64'(m_uf));
  end

  task automatic step();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic drive(bit tv, logic [DW-1:0] d, bit tl, bit rb, bit fl);
    s_axis_tvalid = tv;
    s_axis_tdata  = d;
    s_axis_tlast  = tl;
    rb_ready      = rb;
    flush         = fl;
    step();
  endtask

  task automatic idle();
    drive(0, '0, 0, 0, 0);
  endtask

  logic [DW-1:0] w17;

  initial begin
    rst_n = 1'b0;
    s_axis_tvalid = 0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 0;
    rb_ready      = 0;
    flush         = 0;
    m_clear();
    step();
    step();
    chk("rst_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_spi_data", 64'(spi_data), 64'd0);
    rst_n = 1'b1;
    idle();
    chk("post_rst_tready", 64'(s_axis_tready), 64'd1);

    // Three-word image, no pops.
    drive(1, 32'hDEADBEEF, 0, 0, 0);
    drive(1, 32'h00000013, 0, 0, 0);
    drive(1, 32'h12345678, 1, 0, 0);
    idle();
    chk("img_level", 64'(level), 64'd3);
    chk("img_head", 64'(spi_data), 64'hDEADBEEF);
    chk("img_valid", 64'(valid_o), 64'd1);
    chk("img_last", 64'(last_o), 64'd0);
    chk("img_tready", 64'(s_axis_tready), 64'd0);

    // Drain with rb_ready held; loader stays in done state.
    repeat (4) drive(0, '0, 0, 1, 0);
    chk("drain_done", 64'(frame_done), 64'd1);
    chk("drain_wout", 64'(words_out), 64'd3);
    chk("drain_valid", 64'(valid_o), 64'd0);
    chk("drain_uf", 64'(underflow), 64'd0);
    repeat (2) drive(0, '0, 0, 1, 0);
    drive(0, '0, 0, 0, 1);
    idle();
    chk("flush_tready", 64'(s_axis_tready), 64'd1);
    chk("flush_done", 64'(frame_done), 64'd0);

    // Fill to full, stall a 17th beat, then pop one.
    for (int i = 0; i < 16; i++) drive(1, $urandom, 0, 0, 0);
    chk("full_level", 64'(level), 64'd16);
    chk("full_tready", 64'(s_axis_tready), 64'd0);
    w17 = $urandom;
    drive(1, w17, 0, 0, 0);
    drive(1, w17, 0, 0, 0);
    drive(1, w17, 0, 1, 0);
    drive(1, w17, 0, 0, 0);
    idle();
    chk("wrap_win", 64'(words_in), 64'd17);
    chk("wrap_level", 64'(level), 64'd16);
    repeat (15) drive(0, '0, 0, 1, 0);
    chk("wrap_tail", 64'(spi_data), 64'(w17));
    drive(0, '0, 0, 1, 0);
    idle();
    chk("wrap_empty", 64'(valid_o), 64'd0);
    drive(0, '0, 0, 0, 1);

    // Steady push and pop at level 5.
    for (int i = 0; i < 5; i++) drive(1, $urandom, 0, 0, 0);
    repeat (20) drive(1, $urandom, 0, 1, 0);
    idle();
    chk("steady_level", 64'(level), 64'd5);
    chk("steady_diff", 64'(words_in - words_out), 64'd5);
    repeat (5) drive(0, '0, 0, 1, 0);
    idle();
    chk("steady_uf0", 64'(underflow), 64'd0);

    // Pop strobe while empty before any tlast.
    drive(0, '0, 0, 1, 0);
    idle();
    chk("uf_set", 64'(underflow), 64'd1);
    chk("uf_wout", 64'(words_out), 64'd25);
    drive(0, '0, 0, 0, 1);
    idle();
    chk("uf_clr", 64'(underflow), 64'd0);
    chk("uf_win0", 64'(words_in), 64'd0);
    chk("uf_tready", 64'(s_axis_tready), 64'd1);

    // Randomized traffic with occasional tlast and flush.
    repeat (600) begin
      drive(1'($urandom_range(0, 1)), $urandom,
            $urandom_range(0, 15) == 0,
            1'($urandom_range(0, 1)),
            $urandom_range(0, 39) == 0);
    end
    drive(0, '0, 0, 0, 1);

    // Asynchronous reset mid-burst.
    for (int i = 0; i < 7; i++) drive(1, $urandom, 0, 0, 0);
    chk("pre_rst_level", 64'(level), 64'd7);
    #2;
    rst_n = 1'b0;
    #1;
    m_clear();
    chk("arst_valid", 64'(valid_o), 64'd0);
    chk("arst_level", 64'(level), 64'd0);
    chk("arst_win", 64'(words_in), 64'd0);
    chk("arst_tready", 64'(s_axis_tready), 64'd0);
    idle();
    idle();
    rst_n = 1'b1;
    idle();
    for (int i = 0; i < 4; i++) drive(1, $urandom, i == 3, 0, 0);
    repeat (6) drive(0, '0, 0, 1, 0);
    chk("img2_done", 64'(frame_done), 64'd1);
    chk("img2_wout", 64'(words_out), 64'd4);
    chk("img2_uf", 64'(underflow), 64'd0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
